// File: rtl/uart_pkg.sv
// Shared definitions for the UART transmit arbiter: FSM encoding, timeout
// counter width and a small one-hot helper.
package uart_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_SEND = 2'd2
    } state_t;

    localparam int TO_CNT_W = 16;

    function automatic logic [7:0] onehot8(input logic [2:0] idx);
        onehot8 = 8'h01 << idx;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin search: first set request bit strictly after
// last_owner, wrapping around modulo N_REQ.
module rr_pick #(
    parameter int N_REQ = 4
) (
    input  logic [N_REQ-1:0] req,
    input  logic [2:0]       last_owner,
    output logic [2:0]       winner,
    output logic             valid
);

    int lo_s;
    int dist_s;
    int best_s;

    // Pick the requester with the smallest circular distance from last_owner+1
    always_comb begin
        winner = 3'd0;
        valid  = 1'b0;
        lo_s   = int'(last_owner) % N_REQ;
        dist_s = N_REQ;
        best_s = N_REQ;
        for (int i = 0; i < N_REQ; i++) begin
            dist_s = (i + N_REQ - lo_s - 1) % N_REQ;
            winner = (req[i] && (dist_s < best_s)) ? 3'(i) : winner;
            best_s = (req[i] && (dist_s < best_s)) ? dist_s : best_s;
            valid  = valid | req[i];
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ requesters.
// Optional SEND timeout enabled by defining UART_TX_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int N_REQ  = 4,
    parameter int TO_CYC = 65535
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   req,
    input  logic [8*N_REQ-1:0] req_data,
    output logic [N_REQ-1:0]   gnt,
    output logic [7:0]         tx_data,
    output logic               tx_start,
    input  logic               tx_busy,
    input  logic               tx_done,
    output logic [2:0]         owner,
    output logic               to_err
);

    state_t             state_r;
    logic [N_REQ-1:0]   gnt_r;
    logic               tx_start_r;
    logic [7:0]         tx_data_r;
    logic [2:0]         owner_r;
    logic [2:0]         win_s;
    logic               win_valid_s;
    logic [7:0]         win_byte_s;
    logic [7:0]         onehot_full_s;
    logic [N_REQ-1:0]   win_onehot_s;

`ifdef UART_TX_ARB_TIMEOUT_EN
    localparam logic [TO_CNT_W-1:0] TO_LAST = TO_CNT_W'(TO_CYC - 1);
    logic [TO_CNT_W-1:0] to_cnt_r;
    logic                to_err_r;
`endif

    rr_pick #(.N_REQ(N_REQ)) u_rr_pick (
        .req        (req),
        .last_owner (owner_r),
        .winner     (win_s),
        .valid      (win_valid_s)
    );

    // Decode the winner into its grant vector and select its byte
    always_comb begin
        onehot_full_s = onehot8(win_s);
        win_onehot_s  = onehot_full_s[N_REQ-1:0];
        win_byte_s    = 8'h00;
        for (int i = 0; i < N_REQ; i++) begin
            win_byte_s = (win_s == 3'(i)) ? req_data[8*i +: 8] : win_byte_s;
        end
    end

    // Arbitration FSM; grant, start and captured byte are launched on the IDLE->LOAD edge
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r    <= ST_IDLE;
            gnt_r      <= {N_REQ{1'b0}};
            tx_start_r <= 1'b0;
            tx_data_r  <= 8'h00;
            owner_r    <= 3'(N_REQ - 1);
`ifdef UART_TX_ARB_TIMEOUT_EN
            to_cnt_r   <= {TO_CNT_W{1'b0}};
            to_err_r   <= 1'b0;
`endif
        end else begin
            gnt_r      <= {N_REQ{1'b0}};
            tx_start_r <= 1'b0;
            case (state_r)
                ST_IDLE: begin
                    if (win_valid_s && !tx_busy) begin
                        state_r    <= ST_LOAD;
                        gnt_r      <= win_onehot_s;
                        tx_start_r <= 1'b1;
                        tx_data_r  <= win_byte_s;
                        owner_r    <= win_s;
                    end else begin
                        state_r    <= ST_IDLE;
                    end
                end
                ST_LOAD: begin
                    state_r <= ST_SEND;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    to_cnt_r <= {TO_CNT_W{1'b0}};
`endif
                end
                ST_SEND: begin
                    if (tx_done) begin
                        state_r <= ST_IDLE;
`ifdef UART_TX_ARB_TIMEOUT_EN
                    end else if (to_cnt_r == TO_LAST) begin
                        state_r  <= ST_IDLE;
                        to_err_r <= 1'b1;
                    end else begin
                        to_cnt_r <= to_cnt_r + 16'd1;
                        state_r  <= ST_SEND;
                    end
`else
                    end else begin
                        state_r <= ST_SEND;
                    end
`endif
                end
                default: begin
                    state_r <= ST_IDLE;
                end
            endcase
        end
    end

    assign gnt      = gnt_r;
    assign tx_start = tx_start_r;
    assign tx_data  = tx_data_r;
    assign owner    = owner_r;
`ifdef UART_TX_ARB_TIMEOUT_EN
    assign to_err   = to_err_r;
`else
    assign to_err   = 1'b0;
`endif

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed self-checking bench for uart_tx_arbiter (N_REQ=4, TO_CYC=100).
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

    logic        clk;
    logic        rst_n;
    logic [3:0]  req;
    logic [31:0] req_data;
    logic [3:0]  gnt;
    logic [7:0]  tx_data;
    logic        tx_start;
    logic        tx_busy;
    logic        tx_done;
    logic [2:0]  owner;
    logic        to_err;

    int n_vec;
    int n_err;

    uart_tx_arbiter #(.N_REQ(4), .TO_CYC(100)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req      (req),
        .req_data (req_data),
        .gnt      (gnt),
        .tx_data  (tx_data),
        .tx_start (tx_start),
        .tx_busy  (tx_busy),
        .tx_done  (tx_done),
        .owner    (owner),
        .to_err   (to_err)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_gnt"},      32'(gnt),      32'h0);
        chk({tag, "_start"},    32'(tx_start), 32'h0);
        chk({tag, "_data"},     32'(tx_data),  32'h0);
        chk({tag, "_owner"},    32'(owner),    32'h3);
        chk({tag, "_to_err"},   32'(to_err),   32'h0);
    endtask

    task automatic wait_start(output int lat);
        lat = 0;
        while (!tx_start && lat < 40) begin
            @(negedge clk);
            lat++;
        end
    endtask

    // One full frame: expect the grant one cycle after IDLE, then return tx_done ~20 cycles later
    task automatic do_frame(input string tag, input logic [3:0] exp_gnt, input logic [7:0] exp_byte,
                            input logic [2:0] exp_owner, input logic [3:0] drop_mask);
        int lat;
        wait_start(lat);
        chk({tag, "_lat"},   32'(lat),     32'd1);
        chk({tag, "_gnt"},   32'(gnt),     32'(exp_gnt));
        chk({tag, "_data"},  32'(tx_data), 32'(exp_byte));
        chk({tag, "_owner"}, 32'(owner),   32'(exp_owner));
        req = req & ~drop_mask;
        @(negedge clk);
        chk({tag, "_send_gnt"},   32'(gnt),      32'h0);
        chk({tag, "_send_start"}, 32'(tx_start), 32'h0);
        chk({tag, "_send_data"},  32'(tx_data),  32'(exp_byte));
        repeat (18) @(negedge clk);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
    endtask

    initial begin
        int lat;
        n_vec    = 0;
        n_err    = 0;
        rst_n    = 1'b0;
        req      = 4'b0000;
        req_data = {8'hD3, 8'hC2, 8'hB1, 8'h55};
        tx_busy  = 1'b0;
        tx_done  = 1'b0;
        repeat (2) @(negedge clk);
        chk_reset_outputs("reset");
        rst_n = 1'b1;
        @(negedge clk);

        // Single requester 0, byte 55
        req = 4'b0001;
        do_frame("single0", 4'b0001, 8'h55, 3'd0, 4'b0001);

        // tx_done while IDLE is ignored
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        @(negedge clk);
        chk("idle_done_start", 32'(tx_start), 32'h0);
        chk("idle_done_gnt",   32'(gnt),      32'h0);

        // Fresh reset, then all four requesters held
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        req = 4'b1111;
        do_frame("rr0",  4'b0001, 8'h55, 3'd0, 4'b0000);
        do_frame("rr1",  4'b0010, 8'hB1, 3'd1, 4'b0000);
        do_frame("rr2",  4'b0100, 8'hC2, 3'd2, 4'b0000);
        do_frame("rr3",  4'b1000, 8'hD3, 3'd3, 4'b0000);
        do_frame("rr0b", 4'b0001, 8'h55, 3'd0, 4'b1111);

        // Wrap-around: last owner 2, then req 0101 grants 0 then 2
        req = 4'b0100;
        do_frame("set2",  4'b0100, 8'hC2, 3'd2, 4'b0100);
        req = 4'b0101;
        do_frame("wrap0", 4'b0001, 8'h55, 3'd0, 4'b0001);
        do_frame("wrap2", 4'b0100, 8'hC2, 3'd2, 4'b0100);

        // tx_busy blocks the grant
        tx_busy = 1'b1;
        req = 4'b0010;
        repeat (5) @(negedge clk);
        chk("busy_start", 32'(tx_start), 32'h0);
        chk("busy_gnt",   32'(gnt),      32'h0);
        tx_busy = 1'b0;
        do_frame("busy1", 4'b0010, 8'hB1, 3'd1, 4'b0010);

        // A requester withdrawing before its grant is simply dropped
        tx_busy = 1'b1;
        req = 4'b1000;
        repeat (3) @(negedge clk);
        req = 4'b0000;
        tx_busy = 1'b0;
        repeat (3) @(negedge clk);
        chk("drop_start", 32'(tx_start), 32'h0);
        chk("drop_owner", 32'(owner),    32'h1);

        // Reset asserted in SEND aborts the frame
        req = 4'b0100;
        wait_start(lat);
        chk("abort_lat", 32'(lat), 32'd1);
        req = 4'b0000;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk_reset_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        chk("post_rst_start", 32'(tx_start), 32'h0);
        req = 4'b1000;
        wait_start(lat);
        chk("post_rst_lat",   32'(lat),   32'd1);
        chk("post_rst_gnt",   32'(gnt),   32'h8);
        chk("post_rst_owner", 32'(owner), 32'h3);
        chk("post_rst_data",  32'(tx_data), 32'hD3);
        req = 4'b0000;

`ifdef UART_TX_ARB_TIMEOUT_EN
        // tx_done withheld: 100 SEND cycles then IDLE with to_err
        repeat (100) @(negedge clk);
        chk("to_before", 32'(to_err), 32'h0);
        @(negedge clk);
        chk("to_after",  32'(to_err), 32'h1);
        req = 4'b0001;
        do_frame("to_next", 4'b0001, 8'h55, 3'd0, 4'b0001);
        chk("to_sticky", 32'(to_err), 32'h1);
`else
        // Without the timeout SEND waits indefinitely
        repeat (150) @(negedge clk);
        req = 4'b0001;
        repeat (3) @(negedge clk);
        chk("noto_start", 32'(tx_start), 32'h0);
        chk("noto_err",   32'(to_err),   32'h0);
        tx_done = 1'b1;
        @(negedge clk);
        tx_done = 1'b0;
        do_frame("noto_next", 4'b0001, 8'h55, 3'd0, 4'b0001);
        chk("noto_err2",  32'(to_err),   32'h0);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    // Continuous grant sanity: never more than one bit, never without tx_start
    always @(negedge clk) begin
        if (rst_n && gnt != 4'b0000) begin
            chk("gnt_onehot", 32'($countones(gnt)), 32'd1);
            chk("gnt_with_start", 32'(tx_start), 32'd1);
        end
    end

endmodule
